valu_issue_ctrl: RTL

- Issue controller between instruction decode and the vector ALU stage.
- Accepts one decoded vector op per cycle through a valid/ready handshake and drives the ALU stage inputs: function bits, rD, PPPWW and WB enable.
- Sequences register-shift ops (VSLL/VSLLi/VSRL/VSRLi) as two ALU passes, because the ALU latches its shift amounts one cycle before it uses them.
- Generates operand-forwarding selects from the ALU and WB stages, and squashes illegal width combinations.

---
 rtl/valu_pkg.sv | 46 ++++
 rtl/valu_fwd_unit.sv | 25 ++
 rtl/valu_issue_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// Shared constants and decode helpers for the vector ALU issue controller.
package valu_pkg;

  localparam logic [3:0] OP_VAND   = 4'b0000;
  localparam logic [3:0] OP_VOR    = 4'b0001;
  localparam logic [3:0] OP_VXOR   = 4'b0010;
  localparam logic [3:0] OP_VNOT   = 4'b0011;
  localparam logic [3:0] OP_VMOV   = 4'b0100;
  localparam logic [3:0] OP_VADD   = 4'b0101;
  localparam logic [3:0] OP_VSUB   = 4'b0110;
  localparam logic [3:0] OP_VMULEU = 4'b0111;
  localparam logic [3:0] OP_VMULOU = 4'b1000;
  localparam logic [3:0] OP_VRTTH  = 4'b1001;
  localparam logic [3:0] OP_VSLL   = 4'b1010;
  localparam logic [3:0] OP_VSLLI  = 4'b1011;
  localparam logic [3:0] OP_VSRL   = 4'b1100;
  localparam logic [3:0] OP_VSRLI  = 4'b1101;
  localparam logic [3:0] OP_VSRA   = 4'b1110;
  localparam logic [3:0] OP_VSRAI  = 4'b1111;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SHIFT1 = 2'd2;
  localparam logic [1:0] SHIFT2 = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // A VMOV with writeback disabled is what the ALU sees when nothing is issued.
  localparam logic [5:0] FUNC_BUBBLE = {2'b00, OP_VMOV};

  function automatic logic is_shift2(input logic [3:0] op);
    return (op >= OP_VSLL) && (op <= OP_VSRLI);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op, input logic [1:0] ww);
    return ((op == OP_VMULEU) || (op == OP_VMULOU)) && (ww == WW_64);
  endfunction

endpackage

// File: rtl/valu_fwd_unit.sv
// Forwarding source select for one operand register; ALU stage beats WB stage.
module valu_fwd_unit
  import valu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [0:REG_AW-1] src,
  input  logic [0:REG_AW-1] alu_rD,
  input  logic              alu_wb_en,
  input  logic              alu_fwd_ok,
  input  logic [0:REG_AW-1] wb_rD,
  input  logic              wb_wb_en,
  output logic [0:1]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (alu_wb_en && alu_fwd_ok && (alu_rD == src)) begin
      sel = FWD_ALU;
    end else if (wb_wb_en && (wb_rD == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/valu_issue_ctrl.sv
// Issue controller between vector decode and the vector ALU stage.
// Optional performance counters are enabled with `define VALU_PERF_CNT_EN.
module valu_issue_ctrl
  import valu_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int FUNC_W  = 6,
  parameter int PPPWW_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [0:FUNC_W-1]   dec_function_bit,
  input  logic [0:REG_AW-1]   dec_rA,
  input  logic [0:REG_AW-1]   dec_rB,
  input  logic [0:REG_AW-1]   dec_rD,
  input  logic [0:PPPWW_W-1]  dec_PPPWW,
  input  logic                dec_WB_en,
  output logic [0:FUNC_W-1]   ID_function_bit,
  output logic [0:REG_AW-1]   ID_rD,
  output logic [0:PPPWW_W-1]  ID_PPPWW,
  output logic                ID_WB_en,
  output logic [0:1]          fwd_selA,
  output logic [0:1]          fwd_selB,
  input  logic [0:REG_AW-1]   ALU_rD,
  input  logic                ALU_WB_en,
  input  logic [0:REG_AW-1]   WB_rD,
  input  logic                WB_WB_en,
  output logic                illegal_op,
`ifdef VALU_PERF_CNT_EN
  output logic [0:31]         perf_issued,
  output logic [0:31]         perf_stall,
`endif
  output logic                busy
);

  logic [1:0]        state;
  logic [0:REG_AW-1] pend_rA;
  logic [0:REG_AW-1] pend_rB;
  logic              pend_wb_en;
  logic              transfer;
  logic              reissue;
  logic              squash;
  logic              alu_fwd_ok;
  logic [0:3]        op;
  logic [0:1]        ww;
  logic [0:REG_AW-1] src_a;
  logic [0:REG_AW-1] src_b;
  logic [0:1]        sel_a;
  logic [0:1]        sel_b;

  assign dec_ready = (state != SHIFT1);
  assign busy      = (state != IDLE);
  assign transfer  = dec_valid && dec_ready;
  assign reissue   = (state == SHIFT1);
  assign op        = dec_function_bit[2:5];
  assign ww        = dec_PPPWW[3:4];
  assign squash    = is_illegal(op, ww);

  // The second shift pass re-evaluates forwarding for the held sources, not decode's.
  assign src_a = reissue ? pend_rA : dec_rA;
  assign src_b = reissue ? pend_rB : dec_rB;

  // While in SHIFT2 the ALU output register holds the SHIFT1 pass, which never forwards.
  assign alu_fwd_ok = (state != SHIFT2);

  valu_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src        (src_a),
    .alu_rD     (ALU_rD),
    .alu_wb_en  (ALU_WB_en),
    .alu_fwd_ok (alu_fwd_ok),
    .wb_rD      (WB_rD),
    .wb_wb_en   (WB_WB_en),
    .sel        (sel_a)
  );

  valu_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src        (src_b),
    .alu_rD     (ALU_rD),
    .alu_wb_en  (ALU_WB_en),
    .alu_fwd_ok (alu_fwd_ok),
    .wb_rD      (WB_rD),
    .wb_wb_en   (WB_WB_en),
    .sel        (sel_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ID_function_bit <= '0;
      ID_rD           <= '0;
      ID_PPPWW        <= '0;
      ID_WB_en        <= 1'b0;
      fwd_selA        <= FWD_RF;
      fwd_selB        <= FWD_RF;
      illegal_op      <= 1'b0;
      pend_rA         <= '0;
      pend_rB         <= '0;
      pend_wb_en      <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      if (reissue) begin
        state    <= SHIFT2;
        ID_WB_en <= pend_wb_en;
        fwd_selA <= sel_a;
        fwd_selB <= sel_b;
      end else if (transfer && squash) begin
        state           <= ISSUE;
        ID_function_bit <= FUNC_BUBBLE;
        ID_rD           <= '0;
        ID_PPPWW        <= '0;
        ID_WB_en        <= 1'b0;
        fwd_selA        <= FWD_RF;
        fwd_selB        <= FWD_RF;
        illegal_op      <= 1'b1;
      end else if (transfer) begin
        ID_function_bit <= dec_function_bit;
        ID_rD           <= dec_rD;
        ID_PPPWW        <= dec_PPPWW;
        fwd_selA        <= sel_a;
        fwd_selB        <= sel_b;
        pend_rA         <= dec_rA;
        pend_rB         <= dec_rB;
        pend_wb_en      <= dec_WB_en;
        if (is_shift2(op)) begin
          state    <= SHIFT1;
          ID_WB_en <= 1'b0;
        end else begin
          state    <= ISSUE;
          ID_WB_en <= dec_WB_en;
        end
      end else begin
        state           <= IDLE;
        ID_function_bit <= FUNC_BUBBLE;
        ID_rD           <= '0;
        ID_PPPWW        <= '0;
        ID_WB_en        <= 1'b0;
        fwd_selA        <= FWD_RF;
        fwd_selB        <= FWD_RF;
      end
    end
  end

`ifdef VALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (transfer) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (dec_valid && !dec_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
